// File: rtl/gpio_irq.sv
// gpio_irq: per-pin debounce, edge/level event capture and a masked interrupt behind an APB slave
module gpio_irq #(
    parameter int N_GPIO = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              apbs_psel,
    input  logic              apbs_penable,
    input  logic              apbs_pwrite,
    input  logic [15:0]       apbs_paddr,
    input  logic [31:0]       apbs_pwdata,
    output logic [31:0]       apbs_prdata,
    output logic              apbs_pready,
    output logic              apbs_pslverr,
    input  logic [N_GPIO-1:0] in_i,
    output logic [N_GPIO-1:0] filt_o,
    output logic              irq
);
    logic [N_GPIO-1:0] status, inte, rise, fall, high, low;
    logic [N_GPIO-1:0] filt, filt_nx, ev, w1c;
    logic [7:0]        deb;
    logic [7:0]        cnt [N_GPIO];
    logic              hit, wr;
    logic [2:0]        idx;
    logic              unused;

    assign hit          = apbs_paddr[15:5] == '0;
    assign idx          = apbs_paddr[4:2];
    assign wr           = apbs_psel && apbs_penable && apbs_pwrite && hit;
    assign w1c          = (wr && idx == 3'd0) ? apbs_pwdata[N_GPIO-1:0] : '0;
    assign ev           = (filt_nx & ~filt & rise) | (~filt_nx & filt & fall) | (filt & high) | (~filt & low);
    assign irq          = |(status & inte);
    assign filt_o       = filt;
    assign apbs_pready  = 1'b1;
    assign apbs_pslverr = 1'b0;
    assign unused       = ^{apbs_pwdata[31:8], apbs_paddr[1:0]};

    // filtered value a pin will take on this edge: follow the input once it has differed for D+1 cycles
    always_comb begin
        filt_nx = filt;
        for (int i = 0; i < N_GPIO; i++)
            filt_nx[i] = (in_i[i] != filt[i] && cnt[i] >= deb) ? in_i[i] : filt[i];
    end

    // debounce state: counter restarts whenever the input agrees with filt or filt has just moved
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            filt <= '0;
            for (int i = 0; i < N_GPIO; i++) cnt[i] <= '0;
        end else begin
            filt <= filt_nx;
            for (int i = 0; i < N_GPIO; i++)
                cnt[i] <= (in_i[i] == filt[i] || cnt[i] >= deb) ? 8'd0 : cnt[i] + 8'd1;
        end
    end

    // control registers; a new event outranks a W1C of the same bit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            status <= '0;
            inte   <= '0;
            rise   <= '0;
            fall   <= '0;
            high   <= '0;
            low    <= '0;
            deb    <= '0;
        end else begin
            status <= (status & ~w1c) | ev;
            if (wr) begin
                case (idx)
                    3'd1:    inte <= apbs_pwdata[N_GPIO-1:0];
                    3'd2:    rise <= apbs_pwdata[N_GPIO-1:0];
                    3'd3:    fall <= apbs_pwdata[N_GPIO-1:0];
                    3'd4:    high <= apbs_pwdata[N_GPIO-1:0];
                    3'd5:    low  <= apbs_pwdata[N_GPIO-1:0];
                    3'd6:    deb  <= apbs_pwdata[7:0];
                    default: ;
                endcase
            end
        end
    end

    // read mux, zero outside a read of a mapped address
    always_comb begin
        apbs_prdata = '0;
        if (apbs_psel && !apbs_pwrite && hit) begin
            case (idx)
                3'd0:    apbs_prdata = 32'(status);
                3'd1:    apbs_prdata = 32'(inte);
                3'd2:    apbs_prdata = 32'(rise);
                3'd3:    apbs_prdata = 32'(fall);
                3'd4:    apbs_prdata = 32'(high);
                3'd5:    apbs_prdata = 32'(low);
                3'd6:    apbs_prdata = 32'(deb);
                default: apbs_prdata = 32'(status & inte);
            endcase
        end
    end
endmodule

// File: tb/tb_gpio_irq.sv
// tb_gpio_irq: directed scenario tests for gpio_irq
module tb_gpio_irq;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        psel = 0, penable = 0, pwrite = 0;
    logic [15:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic [31:0] prdata;
    logic        pready, pslverr;
    logic [7:0]  in_i = '0;
    logic [7:0]  filt_o;
    logic        irq;
    int          vecs = 0;
    int          errs = 0;

    gpio_irq #(.N_GPIO(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .apbs_psel(psel), .apbs_penable(penable), .apbs_pwrite(pwrite),
        .apbs_paddr(paddr), .apbs_pwdata(pwdata), .apbs_prdata(prdata),
        .apbs_pready(pready), .apbs_pslverr(pslverr),
        .in_i(in_i), .filt_o(filt_o), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic apb_write(input logic [15:0] a, input logic [31:0] d);
        psel = 1; penable = 0; pwrite = 1; paddr = a; pwdata = d;
        @(posedge clk); #1 penable = 1;
        @(posedge clk); #1 psel = 0; penable = 0; pwrite = 0;
    endtask

    task automatic apb_read(input logic [15:0] a, output logic [31:0] d);
        psel = 1; penable = 0; pwrite = 0; paddr = a;
        @(posedge clk); #1 penable = 1;
        #1 d = prdata;
        @(posedge clk); #1 psel = 0; penable = 0;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        in_i = 8'hff; rst_n = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        vecs++; if (filt_o !== 8'h00) begin errs++; $display("FAIL reset_filt got %h exp 00", filt_o); end
        vecs++; if (irq !== 1'b0) begin errs++; $display("FAIL reset_irq got %b exp 0", irq); end
        vecs++; if (prdata !== 32'h0) begin errs++; $display("FAIL reset_prdata got %h exp 0", prdata); end
        vecs++; if (pready !== 1'b1 || pslverr !== 1'b0) begin errs++; $display("FAIL reset_pready_pslverr got %b%b exp 10", pready, pslverr); end
        for (int r = 0; r < 8; r++) begin
            apb_read(16'(r * 4), d);
            vecs++; if (d !== 32'h0) begin errs++; $display("FAIL reset_reg%0d got %h exp 0", r, d); end
        end
        in_i = 8'h00;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_rise_w1c;
        logic [31:0] d;
        apb_write(16'h18, 32'd3);
        apb_write(16'h08, 32'h01);
        apb_write(16'h04, 32'h01);
        in_i[0] = 1;
        repeat (3) @(posedge clk);
        #1;
        vecs++; if (filt_o[0] !== 1'b0) begin errs++; $display("FAIL rise_early_filt got %b exp 0", filt_o[0]); end
        vecs++; if (irq !== 1'b0) begin errs++; $display("FAIL rise_early_irq got %b exp 0", irq); end
        @(posedge clk); #1;
        vecs++; if (filt_o[0] !== 1'b1) begin errs++; $display("FAIL rise_filt got %b exp 1", filt_o[0]); end
        vecs++; if (irq !== 1'b1) begin errs++; $display("FAIL rise_irq got %b exp 1", irq); end
        apb_read(16'h00, d);
        vecs++; if (d !== 32'h01) begin errs++; $display("FAIL rise_status got %h exp 01", d); end
        apb_write(16'h00, 32'h01);
        vecs++; if (irq !== 1'b0) begin errs++; $display("FAIL w1c_irq got %b exp 0", irq); end
        apb_read(16'h00, d);
        vecs++; if (d !== 32'h00) begin errs++; $display("FAIL w1c_status got %h exp 00", d); end
    endtask

    task automatic test_glitch;
        logic [31:0] d;
        apb_write(16'h18, 32'd4);
        apb_write(16'h08, 32'h09);
        in_i[3] = 1;
        repeat (4) @(posedge clk);
        #1 in_i[3] = 0;
        repeat (3) @(posedge clk);
        #1;
        vecs++; if (filt_o[3] !== 1'b0) begin errs++; $display("FAIL glitch4_filt got %b exp 0", filt_o[3]); end
        apb_read(16'h00, d);
        vecs++; if (d !== 32'h00) begin errs++; $display("FAIL glitch4_status got %h exp 00", d); end
        in_i[3] = 1;
        repeat (5) @(posedge clk);
        #1 in_i[3] = 0;
        vecs++; if (filt_o[3] !== 1'b1) begin errs++; $display("FAIL glitch5_filt got %b exp 1", filt_o[3]); end
        apb_read(16'h00, d);
        vecs++; if (d !== 32'h08) begin errs++; $display("FAIL glitch5_status got %h exp 08", d); end
        apb_write(16'h00, 32'h08);
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic test_level;
        logic [31:0] d;
        apb_write(16'h14, 32'h80);
        apb_write(16'h00, 32'h80);
        apb_read(16'h00, d);
        vecs++; if (d !== 32'h80) begin errs++; $display("FAIL level_held_status got %h exp 80", d); end
        in_i[7] = 1;
        repeat (7) @(posedge clk);
        #1;
        vecs++; if (filt_o[7] !== 1'b1) begin errs++; $display("FAIL level_filt got %b exp 1", filt_o[7]); end
        apb_write(16'h00, 32'h80);
        apb_read(16'h00, d);
        vecs++; if (d !== 32'h00) begin errs++; $display("FAIL level_cleared_status got %h exp 00", d); end
        apb_write(16'h14, 32'h00);
    endtask

    task automatic test_back_to_back;
        logic [31:0] d;
        apb_write(16'h18, 32'd0);
        apb_write(16'h0c, 32'h10);
        in_i[4] = 1;
        repeat (3) @(posedge clk);
        #1 psel = 1; penable = 0; pwrite = 1; paddr = 16'h00; pwdata = 32'h10;
        @(posedge clk);
        #1 penable = 1; in_i[4] = 0;
        @(posedge clk);
        #1 psel = 0; penable = 0; pwrite = 0;
        vecs++; if (filt_o[4] !== 1'b0) begin errs++; $display("FAIL simul_filt got %b exp 0", filt_o[4]); end
        apb_read(16'h00, d);
        vecs++; if (d !== 32'h10) begin errs++; $display("FAIL simul_status got %h exp 10", d); end
        apb_write(16'h00, 32'h10);
        apb_read(16'h00, d);
        vecs++; if (d !== 32'h00) begin errs++; $display("FAIL simul_clear got %h exp 00", d); end
    endtask

    task automatic test_mask_unmapped;
        logic [31:0] d;
        apb_write(16'h0c, 32'h00);
        apb_write(16'h08, 32'h22);
        apb_write(16'h04, 32'h02);
        in_i[1] = 1; in_i[5] = 1;
        repeat (2) @(posedge clk);
        #1;
        vecs++; if (irq !== 1'b1) begin errs++; $display("FAIL mask_irq got %b exp 1", irq); end
        apb_read(16'h00, d);
        vecs++; if (d !== 32'h22) begin errs++; $display("FAIL mask_status got %h exp 22", d); end
        apb_read(16'h1c, d);
        vecs++; if (d !== 32'h02) begin errs++; $display("FAIL mask_ints got %h exp 02", d); end
        apb_read(16'h24, d);
        vecs++; if (d !== 32'h00) begin errs++; $display("FAIL unmapped_read got %h exp 00", d); end
        apb_write(16'h1c, 32'hff);
        apb_write(16'h24, 32'hff);
        apb_read(16'h04, d);
        vecs++; if (d !== 32'h02) begin errs++; $display("FAIL ints_write_inte got %h exp 02", d); end
        apb_read(16'h00, d);
        vecs++; if (d !== 32'h22) begin errs++; $display("FAIL ints_write_status got %h exp 22", d); end
        apb_read(16'h08, d);
        vecs++; if (d !== 32'h22) begin errs++; $display("FAIL rise_readback got %h exp 22", d); end
        apb_write(16'h18, 32'h5a);
        apb_read(16'h18, d);
        vecs++; if (d !== 32'h5a) begin errs++; $display("FAIL deb_readback got %h exp 5a", d); end
        apb_write(16'h04, 32'h00);
        vecs++; if (irq !== 1'b0) begin errs++; $display("FAIL inte_off_irq got %b exp 0", irq); end
        apb_write(16'h04, 32'h20);
        vecs++; if (irq !== 1'b1) begin errs++; $display("FAIL inte_on_irq got %b exp 1", irq); end
    endtask

    task automatic test_reset_midway;
        logic [31:0] d;
        rst_n = 0;
        @(posedge clk);
        #1 rst_n = 1;
        vecs++; if (irq !== 1'b0) begin errs++; $display("FAIL rst2_irq got %b exp 0", irq); end
        vecs++; if (filt_o !== 8'h00) begin errs++; $display("FAIL rst2_filt got %h exp 00", filt_o); end
        apb_read(16'h00, d);
        vecs++; if (d !== 32'h00) begin errs++; $display("FAIL rst2_status got %h exp 00", d); end
        apb_read(16'h04, d);
        vecs++; if (d !== 32'h00) begin errs++; $display("FAIL rst2_inte got %h exp 00", d); end
    endtask

    initial begin
        test_reset;
        test_rise_w1c;
        test_glitch;
        test_level;
        test_back_to_back;
        test_mask_unmapped;
        test_reset_midway;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
